// File: rtl/diff_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the subtractor result path.
// Optional macro SIGNED_RESULT_EN: show a borrow-out result as a negative magnitude instead of an error code.
module diff_bcd_converter #(
    parameter int         WIDTH     = 8,
    parameter logic [3:0] ERR_DIGIT = 4'hE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             error_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             error_out,
    output logic             negative
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t       state;
    logic [WIDTH:0] bin, bin_next;
    logic [11:0]  bcd, bcd_adj, bcd_next;
    logic [3:0]   cnt;

`ifdef SIGNED_RESULT_EN
    localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
    logic           neg_lat;
    logic [WIDTH:0] load_bin;

    // A borrow-out result is value - 2^WIDTH, so its magnitude is 2^WIDTH - value.
    assign load_bin = error_in ? (FULL - {1'b0, value}) : {1'b0, value};
`else
    assign negative = 1'b0;
`endif

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_comb {bcd_next, bin_next} = {bcd_adj, bin} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
            error_out <= 1'b0;
`ifdef SIGNED_RESULT_EN
            neg_lat   <= 1'b0;
            negative  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef SIGNED_RESULT_EN
                        bin     <= load_bin;
                        neg_lat <= error_in;
                        state   <= SHIFT;
`else
                        bin <= {1'b0, value};
                        if (error_in) begin
                            hundreds  <= ERR_DIGIT;
                            tens      <= ERR_DIGIT;
                            ones      <= ERR_DIGIT;
                            error_out <= 1'b1;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            state <= SHIFT;
                        end
`endif
                    end
                end
                SHIFT: begin
                    bcd <= bcd_next;
                    bin <= bin_next;
                    cnt <= cnt + 4'd1;
                    // Final (WIDTH+1)th shift: publish digits straight from the shifted value.
                    if (cnt == 4'(WIDTH)) begin
                        hundreds  <= bcd_next[11:8];
                        tens      <= bcd_next[7:4];
                        ones      <= bcd_next[3:0];
                        error_out <= 1'b0;
`ifdef SIGNED_RESULT_EN
                        negative  <= neg_lat;
`endif
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/diff_bcd_converter.md
Name: diff_bcd_converter

Overview:
- Sequential binary-to-BCD converter on the calculator result path, directly downstream of the 8-bit subtractor.
- Consumes the subtractor's Diff and error (borrow-out) outputs.
- Produces three registered BCD digits and a status flag for the display/segment driver.
- Uses a start/busy/done handshake driven by the calculator control FSM; performs one double-dabble iteration per clock.

Parameters:
- WIDTH, 8, binary input width; supported range 4..8; three BCD digits are always output.
- ERR_DIGIT, 4'hE, digit code driven on all three digits when an error result is displayed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary result (subtractor Diff).
- error_in  input  1  subtractor error (borrow-out, A<B).
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  single-cycle pulse when outputs are valid and updated.
- hundreds  output  4  BCD hundreds digit.
- tens  output  4  BCD tens digit.
- ones  output  4  BCD ones digit.
- error_out  output  1  registered error flag accompanying the digits.
- negative  output  1  sign flag; tied 0 unless SIGNED_RESULT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; digits=0; error_out=0; negative=0.
  - Internal shift register and counter cleared.
  - Takes effect immediately, including mid-conversion.
  - No done is produced for an aborted conversion.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge N:
  - Captures {1'b0,value} into a (WIDTH+1)-bit binary field.
  - Clears the 12-bit BCD field; counter=0.
  - Latches error_in internally.
  - Goes to SHIFT, unless error_in=1 without the feature (see below).
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd,bin} shifts left by 1; counter increments.
  - After WIDTH+1 shifts (edges N+1..N+WIDTH+1) goes to FINISH.
- FINISH:
  - Digits, error_out and negative were loaded on the final shift edge.
  - done=1 for exactly this one cycle; next edge goes to IDLE.
  - Latency: done is high in the cycle following edge N+WIDTH+1 (10 cycles after start for WIDTH=8).
- Error path without the feature:
  - error_in=1 at start: IDLE goes directly to FINISH at edge N.
  - Digits are loaded as ERR_DIGIT×3 and error_out=1; done is high the next cycle (latency 1).
- Outputs:
  - Digits and flags hold their last values until the next done.
  - They never show intermediate shift values.
  - error_out=0 on every non-error completion.
- start while busy, including in FINISH: ignored, not queued.
- start held high continuously: a new conversion begins on the first IDLE cycle after each FINISH.
- value and error_in are don't-care except at the accepting edge.
- Boundary values:
  - value=0 gives 0,0,0.
  - value=2^WIDTH-1 (255) gives 2,5,5.
  - No digit ever exceeds 9 on a non-error result.

Optional Feature:
- Macro: SIGNED_RESULT_EN.
- Defined:
  - error_in=1 is treated as a negative result.
  - Loads magnitude = 2^WIDTH − value into the (WIDTH+1)-bit field; value=0 gives 256.
  - Runs the normal SHIFT path with the same latency as a positive result.
  - On completion, digits show the magnitude, negative=1 and error_out=0.
  - error_in=0 gives negative=0.
- Not defined:
  - Error shortcut as above; negative is constant 0.
  - No magnitude logic is synthesized.

Test Plan:
- Reset, then start with value=8'd0, error_in=0: busy=1 for 10 cycles; done pulse in cycle 10; digits 0,0,0; error_out=0.
- start with value=8'd255: done at cycle 10 with 2,5,5; then start with value=8'd99: 0,9,9 (checks +3 correction at 5..9 boundaries).
- No macro, start with value=8'hF6, error_in=1: done 1 cycle later; digits E,E,E; error_out=1; next value=8'd42 clears error_out and gives 0,4,2.
- SIGNED_RESULT_EN, value=8'hF6 (A=3,B=13), error_in=1: done at cycle 10; 0,1,0; negative=1. Then value=0, error_in=1: 2,5,6; negative=1.
- Pulse start again at cycles 3 and 9 of a conversion: ignored; exactly one done; result matches the first value.
- Assert rst_n=0 mid-SHIFT (cycle 5): all outputs 0 immediately; no done. After release, a fresh start with value=8'd128 gives 1,2,8.
